// File: rtl/timer_pkg.sv
// Shared definitions for the countdown timer: FSM states and default sizes.
package timer_pkg;

  localparam int unsigned DEF_WIDTH     = 8;
  localparam int unsigned DEF_EXP_WIDTH = 4;

  // Saturation value of the expiration counter at its default width.
  localparam logic [DEF_EXP_WIDTH-1:0] EXP_MAX = '1;

  typedef enum logic {
    IDLE = 1'b0,
    RUN  = 1'b1
  } state_e;

endpackage : timer_pkg

// File: rtl/down_count_reg.sv
// Loadable down-count register with terminal flags.
//   clock, reset   : rising-edge clock, async active-high reset (clears to 0)
//   load_i         : capture load_value_i (wins over dec_i)
//   load_value_i   : value captured on load
//   dec_i          : decrement by one; never wraps below zero
//   count_o        : registered count
//   is_one_c       : count_o == 1 (combinational decode)
//   is_zero_c      : count_o == 0 (combinational decode)
module down_count_reg
  import timer_pkg::*;
#(
  parameter int unsigned WIDTH = DEF_WIDTH
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             load_i,
  input  logic [WIDTH-1:0] load_value_i,
  input  logic             dec_i,
  output logic [WIDTH-1:0] count_o,
  output logic             is_one_c,
  output logic             is_zero_c
);

  logic [WIDTH-1:0] count_q;

  // Count register: load beats decrement, decrement stops at zero.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      count_q <= '0;
    end else if (load_i) begin
      count_q <= load_value_i;
    end else if (dec_i && (count_q != '0)) begin
      count_q <= count_q - WIDTH'(1);
    end
  end

  assign count_o   = count_q;
  assign is_one_c  = (count_q == WIDTH'(1));
  assign is_zero_c = (count_q == '0);

endmodule : down_count_reg

// File: rtl/countdown_timer.sv
// Loadable down-counter / timeout generator with optional periodic reload.
//   clock, reset : rising-edge clock, async active-high reset
//   load         : capture load_value into count and reload register
//   load_value   : start value
//   start        : begin counting from IDLE (ignored while busy)
//   stop         : return to IDLE, count holds
//   auto_reload  : at terminal count, reload and keep running
//   count        : current count (registered)
//   busy         : high while running (registered)
//   done         : one-cycle pulse per terminal count (registered)
//   expirations  : saturating count of terminal counts (registered)
module countdown_timer
  import timer_pkg::*;
#(
  parameter int unsigned WIDTH     = DEF_WIDTH,
  parameter int unsigned EXP_WIDTH = DEF_EXP_WIDTH
) (
  input  logic                 clock,
  input  logic                 reset,
  input  logic                 load,
  input  logic [WIDTH-1:0]     load_value,
  input  logic                 start,
  input  logic                 stop,
  input  logic                 auto_reload,
  output logic [WIDTH-1:0]     count,
  output logic                 busy,
  output logic                 done,
  output logic [EXP_WIDTH-1:0] expirations
);

  localparam logic [EXP_WIDTH-1:0] EXP_SAT = '1;

  state_e               state_q, state_d;
  logic [WIDTH-1:0]     reload_q, reload_d;
  logic                 done_q, done_d;
  logic                 busy_q;
  logic [EXP_WIDTH-1:0] exp_q, exp_d;

  logic                 cnt_load_c;
  logic [WIDTH-1:0]     cnt_value_c;
  logic                 cnt_dec_c;
  logic                 is_one_c, is_zero_c;
  logic                 term_c;
  logic                 rearm_c;
  logic                 exp_inc_c;

  down_count_reg #(
    .WIDTH (WIDTH)
  ) u_count (
    .clock        (clock),
    .reset        (reset),
    .load_i       (cnt_load_c),
    .load_value_i (cnt_value_c),
    .dec_i        (cnt_dec_c),
    .count_o      (count),
    .is_one_c     (is_one_c),
    .is_zero_c    (is_zero_c)
  );

  // A zero count while running only arises from a load of 0 and is terminal too.
  assign term_c  = (state_q == RUN) && (is_one_c || is_zero_c);
  assign rearm_c = auto_reload && (reload_q != '0);

  // State register.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next state: load > stop > start > terminal/decrement.
  always_comb begin
    state_d = state_q;
    if (load) begin
      if (stop) begin
        state_d = IDLE;
      end
    end else if (stop) begin
      state_d = IDLE;
    end else if (state_q == IDLE) begin
      if (start && !is_zero_c) begin
        state_d = RUN;
      end
    end else if (term_c && !rearm_c) begin
      state_d = IDLE;
    end
  end

  // Datapath controls and next values of the registered outputs.
  always_comb begin
    cnt_load_c  = 1'b0;
    cnt_value_c = load_value;
    cnt_dec_c   = 1'b0;
    reload_d    = reload_q;
    done_d      = 1'b0;
    exp_inc_c   = 1'b0;
    if (load) begin
      cnt_load_c = 1'b1;
      reload_d   = load_value;
    end else if (stop) begin
      // Count holds; no pulse.
      cnt_load_c = 1'b0;
    end else if (state_q == IDLE) begin
      // Zero-length timeout: start on an empty count expires at once.
      if (start && is_zero_c) begin
        done_d    = 1'b1;
        exp_inc_c = 1'b1;
      end
    end else if (term_c) begin
      done_d      = 1'b1;
      exp_inc_c   = 1'b1;
      cnt_load_c  = 1'b1;
      cnt_value_c = rearm_c ? reload_q : '0;
    end else begin
      cnt_dec_c = 1'b1;
    end
    exp_d = (exp_inc_c && (exp_q != EXP_SAT)) ? exp_q + EXP_WIDTH'(1) : exp_q;
  end

  // Output and reload registers.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      reload_q <= '0;
      done_q   <= 1'b0;
      busy_q   <= 1'b0;
      exp_q    <= '0;
    end else begin
      reload_q <= reload_d;
      done_q   <= done_d;
      busy_q   <= (state_d == RUN);
      exp_q    <= exp_d;
    end
  end

  assign busy        = busy_q;
  assign done        = done_q;
  assign expirations = exp_q;

endmodule : countdown_timer

// File: tb/tb_countdown_timer.sv
// Self-checking bench for countdown_timer: directed scenarios with literal
// expectations plus randomized traffic against a behavioural model.
module tb_countdown_timer;

  localparam int unsigned W     = 8;
  localparam int unsigned EXP_W = 4;
  localparam int          EXP_MAX_I = (1 << EXP_W) - 1;

  logic             clock = 1'b0;
  logic             reset;
  logic             load;
  logic [W-1:0]     load_value;
  logic             start;
  logic             stop;
  logic             auto_reload;
  logic [W-1:0]     count;
  logic             busy;
  logic             done;
  logic [EXP_W-1:0] expirations;

  int checks = 0;
  int errors = 0;
  bit chk_en = 1'b0;

  // Behavioural model state (plain integers).
  int m_cnt, m_rel, m_exp;
  bit m_run, m_done;

  countdown_timer #(
    .WIDTH     (W),
    .EXP_WIDTH (EXP_W)
  ) dut (
    .clock       (clock),
    .reset       (reset),
    .load        (load),
    .load_value  (load_value),
    .start       (start),
    .stop        (stop),
    .auto_reload (auto_reload),
    .count       (count),
    .busy        (busy),
    .done        (done),
    .expirations (expirations)
  );

  always #5 clock = ~clock;

  task automatic chk(input string name, input int got, input int want);
    checks++;
    if (got != want) begin
      errors++;
      $display("FAIL %s got %0d want %0d at %0t", name, got, want, $time);
    end
  endtask

  // Model: apply the timer rules to the inputs seen at each rising edge.
  always @(posedge clock or posedge reset) begin
    if (reset) begin
      m_cnt <= 0; m_rel <= 0; m_run <= 1'b0; m_done <= 1'b0; m_exp <= 0;
    end else begin
      m_done <= 1'b0;
      if (load) begin
        m_cnt <= int'(load_value);
        m_rel <= int'(load_value);
        if (stop) m_run <= 1'b0;
      end else if (stop) begin
        m_run <= 1'b0;
      end else if (!m_run) begin
        if (start) begin
          if (m_cnt == 0) begin
            m_done <= 1'b1;
            m_exp  <= (m_exp < EXP_MAX_I) ? m_exp + 1 : EXP_MAX_I;
          end else begin
            m_run <= 1'b1;
          end
        end
      end else if (m_cnt <= 1) begin
        m_done <= 1'b1;
        m_exp  <= (m_exp < EXP_MAX_I) ? m_exp + 1 : EXP_MAX_I;
        if (auto_reload && m_rel != 0) begin
          m_cnt <= m_rel;
        end else begin
          m_cnt <= 0;
          m_run <= 1'b0;
        end
      end else begin
        m_cnt <= m_cnt - 1;
      end
    end
  end

  // Single compare process against the model, mid-cycle on the falling edge.
  always @(negedge clock) begin
    if (chk_en) begin
      chk("model_count", int'(count), m_cnt);
      chk("model_busy", int'(busy), int'(m_run));
      chk("model_done", int'(done), int'(m_done));
      chk("model_exp", int'(expirations), m_exp);
    end
  end

  // Advance one clock; returns just after the falling edge.
  task automatic cyc();
    @(negedge clock);
    #1;
  endtask

  task automatic idle_inputs();
    load = 1'b0; start = 1'b0; stop = 1'b0;
  endtask

  int pulses;

  initial begin
    reset = 1'b1; load = 1'b0; load_value = '0; start = 1'b0;
    stop = 1'b0; auto_reload = 1'b0;
    cyc(); cyc();
    reset = 1'b0;
    chk_en = 1'b1;
    cyc();
    chk("rst_count", int'(count), 0);
    chk("rst_busy", int'(busy), 0);
    chk("rst_done", int'(done), 0);
    chk("rst_exp", int'(expirations), 0);

    // 1: load 5, start, busy for 5 cycles, then done with count 0.
    load = 1'b1; load_value = 8'd5; cyc(); idle_inputs();
    chk("t1_loaded", int'(count), 5);
    start = 1'b1; cyc(); idle_inputs();
    chk("t1_start_cnt", int'(count), 5);
    chk("t1_start_busy", int'(busy), 1);
    for (int i = 4; i >= 1; i--) begin
      cyc();
      chk("t1_cnt", int'(count), i);
      chk("t1_busy", int'(busy), 1);
      chk("t1_nodone", int'(done), 0);
    end
    cyc();
    chk("t1_end_cnt", int'(count), 0);
    chk("t1_end_done", int'(done), 1);
    chk("t1_end_busy", int'(busy), 0);
    chk("t1_end_exp", int'(expirations), 1);
    cyc();
    chk("t1_done_once", int'(done), 0);

    // 2: periodic reload with N=3: four pulses in 12 cycles.
    load = 1'b1; load_value = 8'd3; auto_reload = 1'b1; cyc(); idle_inputs();
    start = 1'b1; cyc(); idle_inputs();
    pulses = 0;
    for (int i = 1; i <= 12; i++) begin
      cyc();
      chk("t2_cnt", int'(count), (i % 3 == 0) ? 3 : 3 - (i % 3));
      chk("t2_done", int'(done), (i % 3 == 0) ? 1 : 0);
      chk("t2_busy", int'(busy), 1);
      if (done) pulses++;
    end
    chk("t2_pulses", pulses, 4);
    stop = 1'b1; cyc(); idle_inputs(); auto_reload = 1'b0;
    chk("t2_stopped", int'(busy), 0);
    chk("t2_exp", int'(expirations), 5);

    // 3: stop mid-run holds the count; restart finishes the remainder.
    load = 1'b1; load_value = 8'd10; cyc(); idle_inputs();
    start = 1'b1; cyc(); idle_inputs();
    repeat (4) cyc();
    chk("t3_pre_stop", int'(count), 6);
    stop = 1'b1; cyc(); idle_inputs();
    chk("t3_hold_cnt", int'(count), 6);
    chk("t3_hold_busy", int'(busy), 0);
    chk("t3_hold_done", int'(done), 0);
    cyc();
    chk("t3_still", int'(count), 6);
    start = 1'b1; cyc(); idle_inputs();
    repeat (5) cyc();
    chk("t3_before_done", int'(done), 0);
    cyc();
    chk("t3_done", int'(done), 1);
    chk("t3_cnt0", int'(count), 0);
    chk("t3_exp", int'(expirations), 6);

    // 4: zero-length timeout.
    load = 1'b1; load_value = 8'd0; cyc(); idle_inputs();
    start = 1'b1; cyc(); idle_inputs();
    chk("t4_done", int'(done), 1);
    chk("t4_busy", int'(busy), 0);
    chk("t4_exp", int'(expirations), 7);
    cyc();
    chk("t4_done_once", int'(done), 0);

    // 5: reload mid-run, then load together with stop.
    load = 1'b1; load_value = 8'd20; cyc(); idle_inputs();
    start = 1'b1; cyc(); idle_inputs();
    repeat (13) cyc();
    chk("t5_at7", int'(count), 7);
    load = 1'b1; load_value = 8'd2; cyc(); idle_inputs();
    chk("t5_reload", int'(count), 2);
    chk("t5_reload_busy", int'(busy), 1);
    cyc();
    chk("t5_one", int'(count), 1);
    cyc();
    chk("t5_done", int'(done), 1);
    chk("t5_busy_low", int'(busy), 0);
    load = 1'b1; load_value = 8'd9; cyc(); idle_inputs();
    start = 1'b1; cyc(); idle_inputs();
    cyc();
    load = 1'b1; stop = 1'b1; load_value = 8'd4; cyc(); idle_inputs();
    chk("t5_ls_cnt", int'(count), 4);
    chk("t5_ls_busy", int'(busy), 0);

    // 6: asynchronous reset mid-run at count 4, then expiration saturation.
    load = 1'b1; load_value = 8'd6; cyc(); idle_inputs();
    start = 1'b1; cyc(); idle_inputs();
    cyc(); cyc();
    chk("t6_at4", int'(count), 4);
    #2 reset = 1'b1;
    #1;
    chk("t6_async_cnt", int'(count), 0);
    chk("t6_async_busy", int'(busy), 0);
    chk("t6_async_exp", int'(expirations), 0);
    cyc();
    reset = 1'b0;
    start = 1'b1;
    repeat (EXP_MAX_I + 5) cyc();
    idle_inputs();
    chk("t6_sat", int'(expirations), EXP_MAX_I);
    chk("t6_sat_done", int'(done), 1);

    // Randomized traffic; the compare process checks every cycle.
    for (int n = 0; n < 4000; n++) begin
      load        = ($urandom_range(0, 9) == 0);
      load_value  = ($urandom_range(0, 3) == 0) ? W'($urandom) : W'($urandom_range(0, 6));
      start       = ($urandom_range(0, 3) == 0);
      stop        = ($urandom_range(0, 19) == 0);
      auto_reload = ($urandom_range(0, 1) == 1);
      reset       = ($urandom_range(0, 599) == 0);
      cyc();
    end
    idle_inputs();
    reset = 1'b0;
    cyc();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule : tb_countdown_timer
